// File: rtl/rca_pipe_addsub.sv
// ============================================================================
// Module   : rca_pipe_addsub
// Function : Pipelined ripple-carry adder/subtractor, one WIDTH/STAGES-bit chunk
//            per stage, valid/ready handshake on both sides.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int c_chunk = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < STAGES || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("rca_pipe_addsub: WIDTH must be a nonzero multiple of STAGES");
    end

    // Index s holds the inputs of stage s; w_vld[STAGES] is the output valid.
    wire             w_vld [STAGES+1];
    wire [WIDTH-1:0] w_a   [STAGES];
    wire [WIDTH-1:0] w_b   [STAGES];
    wire [WIDTH-1:0] w_sum [STAGES];
    wire             w_sub [STAGES];
    wire             w_c   [STAGES];
    wire             w_adv;

    // The whole pipe moves as one; it only freezes behind a stalled result.
    assign w_adv     = out_ready | ~w_vld[STAGES];
    assign in_ready  = w_adv;
    assign out_valid = w_vld[STAGES];

    assign w_vld[0] = in_valid;
    assign w_a[0]   = A;
    assign w_b[0]   = B;
    assign w_sub[0] = sub;
    assign w_c[0]   = sub | Cin;
    assign w_sum[0] = '0;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_lo = s * c_chunk;

        logic [WIDTH-1:0] w_sum_n;
        logic             w_co;
        logic             w_cmsb;

        always_comb begin
            logic w_carry;
            logic w_bx;
            w_carry = w_c[s];
            w_bx    = 1'b0;
            w_sum_n = w_sum[s];
            w_cmsb  = w_c[s];
            for (int i = 0; i < c_chunk; i++) begin
                w_bx               = w_b[s][c_lo+i] ^ w_sub[s];
                w_sum_n[c_lo+i]    = w_a[s][c_lo+i] ^ w_bx ^ w_carry;
                w_cmsb             = w_carry;
                w_carry            = (w_a[s][c_lo+i] & w_bx) |
                                     (w_carry & (w_a[s][c_lo+i] ^ w_bx));
            end
            w_co = w_carry;
        end

        if (s < STAGES - 1) begin : g_mid
            logic             r_vld;
            logic             r_sub;
            logic             r_c;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_sum;
            logic             w_unused_cmsb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_sub <= 1'b0;
                    r_c   <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_vld <= w_vld[s];
                    r_sub <= w_sub[s];
                    r_c   <= w_co;
                    r_a   <= w_a[s];
                    r_b   <= w_b[s];
                    r_sum <= w_sum_n;
                end
            end

            assign w_vld[s+1] = r_vld;
            assign w_sub[s+1] = r_sub;
            assign w_c[s+1]   = r_c;
            assign w_a[s+1]   = r_a;
            assign w_b[s+1]   = r_b;
            assign w_sum[s+1] = r_sum;
            assign w_unused_cmsb = w_cmsb;
        end else begin : g_last
            logic             r_vld;
            logic             r_cout;
            logic             r_ovf;
            logic [WIDTH-1:0] r_sum;

            // Result registers keep the last retired value across bubbles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_sum  <= '0;
                end else if (w_adv) begin
                    r_vld <= w_vld[s];
                    if (w_vld[s]) begin
                        r_sum  <= w_sum_n;
                        r_cout <= w_co;
                        r_ovf  <= w_co ^ w_cmsb;
                    end
                end
            end

            assign w_vld[STAGES] = r_vld;
            assign Sum           = r_sum;
            assign Cout          = r_cout;
            assign Ovf           = r_ovf;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rca_pipe_addsub.sv
// ============================================================================
// Module   : tb_rca_pipe_addsub
// Function : Directed-vector and scoreboard bench for rca_pipe_addsub (16/4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rca_pipe_addsub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout;
    logic        Ovf;

    int n_chk = 0;
    int n_err = 0;

    rca_pipe_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] golden(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sb);
        logic [15:0] bx;
        logic [16:0] t;
        logic        ov;
        bx = sb ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + {16'd0, (sb ? 1'b1 : cin)};
        ov = (a[15] == bx[15]) && (t[15] != a[15]);
        return {ov, t[16], t[15:0]};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [11];
        logic [17:0] q [$];
        bit          pat [7];
        logic [15:0] held_sum;
        logic        held_c;
        logic        held_o;
        logic [17:0] obs;
        bit          was_stall;
        bit          saw_block;
        bit          seen;
        bit          acc;
        bit          ret;
        int          acc_i;
        int          ret_i;
        int          n_ops;

        vt[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vt[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[4]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vt[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vt[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vt[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vt[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[10] = '{16'h0F0F, 16'hF0F0, 1'b0, 1'b1, 16'h1E1F, 1'b0, 1'b0};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_sum", {16'd0, Sum}, 32'd0);
        chk("reset_cout", {31'd0, Cout}, 32'd0);
        chk("reset_ovf", {31'd0, Ovf}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Single ops: exact 4-cycle latency and hand-computed results.
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; A = vt[i].a; B = vt[i].b; Cin = vt[i].cin; sub = vt[i].sub;
            tick();
            in_valid = 1'b0;
            tick();
            tick();
            chk($sformatf("v%0d_early", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_sum", i), {16'd0, Sum}, {16'd0, vt[i].sum});
            chk($sformatf("v%0d_cout", i), {31'd0, Cout}, {31'd0, vt[i].cout});
            chk($sformatf("v%0d_ovf", i), {31'd0, Ovf}, {31'd0, vt[i].ovf});
        end
        tick();
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_sum_hold", {16'd0, Sum}, {16'd0, vt[10].sum});

        // Streaming with backpressure.
        acc_i = 0; ret_i = 0; was_stall = 1'b0; saw_block = 1'b0;
        held_sum = '0; held_c = 1'b0; held_o = 1'b0;
        for (int cyc = 0; cyc < 80 && ret_i < 8; cyc++) begin
            out_ready = pat[cyc % 7];
            in_valid  = (acc_i < 8);
            A = 16'(acc_i); B = 16'(acc_i * 'h1000); Cin = 1'b0; sub = 1'b0;
            #3;
            if (was_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_sum", {16'd0, Sum}, {16'd0, held_sum});
                chk("stall_flags", {30'd0, Cout, Ovf}, {30'd0, held_c, held_o});
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                saw_block = 1'b1;
                was_stall = 1'b1;
                held_sum = Sum; held_c = Cout; held_o = Ovf;
            end else begin
                was_stall = 1'b0;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d_sum", ret_i), {16'd0, Sum}, 32'(16'(ret_i * 'h1001)));
                chk($sformatf("stream%0d_flags", ret_i), {30'd0, Cout, Ovf}, 32'd0);
                ret_i++;
            end
            tick();
            if (acc) acc_i++;
        end
        chk("stream_count", 32'(ret_i), 32'd8);
        chk("stream_blocked", {31'd0, saw_block}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Reset with ops in flight, including one presented during reset.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; A = 16'(16'h0100 + k); B = 16'h0001; Cin = 1'b0; sub = 1'b0;
            tick();
        end
        rst = 1'b1; A = 16'h0200;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, Sum}, 32'd0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_stale", {31'd0, seen}, 32'd0);
        in_valid = 1'b1; A = 16'h1111; B = 16'h2222;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("postrst_early", {31'd0, out_valid}, 32'd0);
        tick();
        chk("postrst_valid", {31'd0, out_valid}, 32'd1);
        chk("postrst_sum", {16'd0, Sum}, 32'h3333);
        tick();

        // Random traffic against a golden model.
        n_ops = 0;
        for (int cyc = 0; cyc < 8000 && n_ops < 2000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = 16'($urandom);
            B         = 16'($urandom);
            Cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            #3;
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            obs = {Ovf, Cout, Sum};
            tick();
            if (acc) begin
                q.push_back(golden(A, B, Cin, sub));
                n_ops++;
            end
            if (ret) begin
                if (q.size() == 0) chk("rnd_unexpected", 32'd1, 32'd0);
                else chk("rnd_result", {14'd0, obs}, {14'd0, q.pop_front()});
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #3;
            ret = out_valid;
            obs = {Ovf, Cout, Sum};
            tick();
            if (ret) begin
                if (q.size() == 0) chk("rnd_unexpected", 32'd1, 32'd0);
                else chk("rnd_result", {14'd0, obs}, {14'd0, q.pop_front()});
            end
        end
        chk("rnd_ops", 32'(n_ops), 32'd2000);
        chk("rnd_drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
